// File: rtl/cook_timer.sv
// Microwave keypad front end and cook countdown.
// Countdown advances only while the controller reports heat.
module cook_timer #(
  parameter int TICK_DIV = 1000,
  parameter int ADD_SEC  = 30,
  parameter int MAX_SEC  = 5999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_add,
  input  logic        key_start,
  input  logic        key_stop,
  input  logic        door,
  input  logic        heat,
  input  logic        bell,
  output logic        start,
  output logic        finish,
  output logic        running,
  output logic [12:0] remaining,
  output logic [6:0]  minutes,
  output logic [5:0]  seconds
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [13:0] ADD = 14'(ADD_SEC);
  localparam logic [13:0] MAX = 14'(MAX_SEC);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    RUN,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [12:0]   rem_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          start_d;
  logic          tick;
  logic          go;
  logic          any_add;

  function automatic logic [12:0] sat(input logic [13:0] x);
    return (x > MAX) ? MAX[12:0] : x[12:0];
  endfunction

  assign tick    = heat && (pre_q == PW'(TICK_DIV - 1));
  assign go      = key_start && !door && !bell;
  assign any_add = key_add || key_start;

  always_comb begin
    state_d = state_q;
    rem_d   = remaining;
    pre_d   = pre_q;
    start_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!key_stop) begin
          if (go) begin
            rem_d   = sat(ADD);
            start_d = 1'b1;
            pre_d   = '0;
            state_d = RUN;
          end else if (key_add) begin
            rem_d   = sat(ADD);
            state_d = ARMED;
          end
        end
      end
      ARMED: begin
        if (key_stop) begin
          rem_d   = '0;
          state_d = IDLE;
        end else begin
          if (key_add)
            rem_d = sat({1'b0, remaining} + ADD);
          if (go) begin
            start_d = 1'b1;
            pre_d   = '0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (key_stop) begin
          rem_d   = '0;
          state_d = DONE;
        end else begin
          if (heat)
            pre_d = tick ? '0 : pre_q + PW'(1);
          // remaining is at least 1 here, so the decrement never wraps
          rem_d = sat({1'b0, remaining} - 14'(tick)
                      + (any_add ? ADD : 14'd0));
          if (rem_d == 13'd0)
            state_d = DONE;
        end
      end
      DONE: begin
        if (bell)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      remaining <= '0;
      pre_q     <= '0;
      start     <= 1'b0;
      finish    <= 1'b0;
      running   <= 1'b0;
    end else begin
      state_q   <= state_d;
      remaining <= rem_d;
      pre_q     <= pre_d;
      start     <= start_d;
      finish    <= (state_d == DONE);
      running   <= (state_d == RUN);
    end
  end

  assign minutes = 7'(remaining / 13'd60);
  assign seconds = 6'(remaining % 13'd60);

endmodule

// File: tb/tb_cook_timer.sv
// Bench for cook_timer: directed scenarios plus random keys,
// all cycles compared against a behavioural oven model.
module tb_cook_timer;

  localparam int TD = 4;
  localparam int AS = 30;
  localparam int MS = 5999;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_add = 1'b0;
  logic        key_start = 1'b0;
  logic        key_stop = 1'b0;
  logic        door = 1'b0;
  logic        heat = 1'b0;
  logic        bell = 1'b0;
  logic        start;
  logic        finish;
  logic        running;
  logic [12:0] remaining;
  logic [6:0]  minutes;
  logic [5:0]  seconds;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // model: mode 0 empty, 1 armed, 2 cooking, 3 waiting for bell
  int mmode = 0;
  int mrem = 0;
  int mheat = 0;
  bit mstart = 1'b0;

  cook_timer #(
    .TICK_DIV(TD),
    .ADD_SEC(AS),
    .MAX_SEC(MS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key_add(key_add),
    .key_start(key_start),
    .key_stop(key_stop),
    .door(door),
    .heat(heat),
    .bell(bell),
    .start(start),
    .finish(finish),
    .running(running),
    .remaining(remaining),
    .minutes(minutes),
    .seconds(seconds)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  always @(posedge clk or posedge rst) begin : model
    bit go;
    int t;
    if (rst) begin
      mmode  = 0;
      mrem   = 0;
      mheat  = 0;
      mstart = 1'b0;
    end else begin
      mstart = 1'b0;
      go = key_start && !door && !bell;
      t = 0;
      case (mmode)
        0: if (!key_stop) begin
          if (go) begin
            mrem = min2(AS, MS);
            mstart = 1'b1;
            mmode = 2;
            mheat = 0;
          end else if (key_add) begin
            mrem = min2(AS, MS);
            mmode = 1;
          end
        end
        1: if (key_stop) begin
          mrem = 0;
          mmode = 0;
        end else begin
          if (key_add) mrem = min2(mrem + AS, MS);
          if (go) begin
            mstart = 1'b1;
            mmode = 2;
            mheat = 0;
          end
        end
        2: if (key_stop) begin
          mrem = 0;
          mmode = 3;
        end else begin
          if (heat) begin
            mheat++;
            if (mheat % TD == 0) t = 1;
          end
          mrem = min2(mrem - t + ((key_add || key_start) ? AS : 0), MS);
          if (mrem == 0) mmode = 3;
        end
        default: if (bell) mmode = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("start", int'(start), int'(mstart));
      check("finish", int'(finish), int'(mmode == 3));
      check("running", int'(running), int'(mmode == 2));
      check("remaining", int'(remaining), mrem);
      check("minutes", int'(minutes), mrem / 60);
      check("seconds", int'(seconds), mrem % 60);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic add_pulse();
    key_add = 1'b1;
    cyc(1);
    key_add = 1'b0;
  endtask

  task automatic stop_pulse();
    key_stop = 1'b1;
    cyc(1);
    key_stop = 1'b0;
  endtask

  task automatic bell_pulse();
    bell = 1'b1;
    cyc(1);
    bell = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(2);
    check("rst_start", int'(start), 0);
    check("rst_finish", int'(finish), 0);
    check("rst_running", int'(running), 0);
    check("rst_remaining", int'(remaining), 0);
    rst = 1'b0;
    cmp_en = 1'b1;
    cyc(2);

    // quick start: 30 s is 120 heat cycles
    heat = 1'b1;
    key_start = 1'b1;
    cyc(1);
    key_start = 1'b0;
    check("qs_start", int'(start), 1);
    check("qs_rem", int'(remaining), 30);
    cyc(1);
    check("qs_start_once", int'(start), 0);
    cyc(118);
    check("qs_fin_early", int'(finish), 0);
    cyc(1);
    check("qs_fin", int'(finish), 1);
    check("qs_rem0", int'(remaining), 0);
    cyc(3);
    bell_pulse();
    check("qs_bell", int'(finish), 0);
    cyc(2);

    // add then door pause
    heat = 1'b0;
    repeat (3) add_pulse();
    check("add_rem", int'(remaining), 90);
    check("add_min", int'(minutes), 1);
    check("add_sec", int'(seconds), 30);
    key_start = 1'b1;
    cyc(1);
    key_start = 1'b0;
    heat = 1'b1;
    cyc(10);
    check("pause_rem88", int'(remaining), 88);
    heat = 1'b0;
    cyc(50);
    check("pause_hold", int'(remaining), 88);
    heat = 1'b1;
    cyc(1);
    check("pause_pre1", int'(remaining), 88);
    cyc(1);
    check("pause_tick", int'(remaining), 87);
    stop_pulse();
    check("stop_fin", int'(finish), 1);
    bell_pulse();
    cyc(1);

    // saturation and door-open start
    repeat (200) add_pulse();
    check("sat_rem", int'(remaining), 5999);
    check("sat_min", int'(minutes), 99);
    check("sat_sec", int'(seconds), 59);
    add_pulse();
    check("sat_hold", int'(remaining), 5999);
    door = 1'b1;
    key_start = 1'b1;
    cyc(1);
    key_start = 1'b0;
    check("door_nostart", int'(start), 0);
    check("door_norun", int'(running), 0);
    stop_pulse();
    check("door_stop", int'(remaining), 0);
    door = 1'b0;
    cyc(1);

    // tick and add on the final second
    heat = 1'b1;
    key_start = 1'b1;
    cyc(1);
    key_start = 1'b0;
    cyc(119);
    check("bnd_rem1", int'(remaining), 1);
    add_pulse();
    check("bnd_rem30", int'(remaining), 30);
    check("bnd_nofin", int'(finish), 0);
    cyc(7);
    stop_pulse();
    check("bnd_stop_fin", int'(finish), 1);
    cyc(5);
    check("bnd_fin_held", int'(finish), 1);
    bell_pulse();
    check("bnd_bell", int'(finish), 0);

    // reset in the middle of a run
    heat = 1'b0;
    key_start = 1'b1;
    cyc(1);
    key_start = 1'b0;
    add_pulse();
    heat = 1'b1;
    cyc(60);
    check("mid_rem45", int'(remaining), 45);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_rem", int'(remaining), 0);
    check("mid_rst_run", int'(running), 0);
    check("mid_rst_fin", int'(finish), 0);
    cyc(2);
    rst = 1'b0;
    cyc(3);
    check("mid_no_start", int'(start), 0);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      key_add   = ($urandom % 20) == 0;
      key_start = ($urandom % 25) == 0;
      key_stop  = ($urandom % 60) == 0;
      if (($urandom % 200) == 0) door = ~door;
      heat = ($urandom % 8) != 0;
      bell = (mmode == 3) ? (($urandom % 3) == 0)
                          : (($urandom % 50) == 0);
      cyc(1);
    end
    key_add = 1'b0;
    key_start = 1'b0;
    key_stop = 1'b0;
    bell = 1'b0;
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
